age_sel_issue: RTL

//  Parametrised, registered, oldest-first issue selector for the reservation station.

---
 rtl/age_sel_issue_if.sv | 28 ++
 rtl/age_sel_issue.sv | 134 +++++++++++++
 2 files changed

// File: rtl/age_sel_issue_if.sv
// Bundles the request side (req/age/head/flush/ready) and the grant side (valid/idx/fire) of the issue selector.
// The master drives requests and FU readiness; the slave presents the registered grants.
interface age_sel_issue_if #(
    parameter int N_ENTRIES = 16,
    parameter int N_GRANT   = 2,
    parameter int AGE_W     = 5
);
    localparam int IDX_W = $clog2(N_ENTRIES);

    logic                         flush;
    logic [N_ENTRIES-1:0]         req;
    logic [N_ENTRIES*AGE_W-1:0]   age;
    logic [AGE_W-1:0]             head_age;
    logic [N_GRANT-1:0]           out_ready;
    logic [N_GRANT-1:0]           gnt_valid;
    logic [N_GRANT*IDX_W-1:0]     gnt_idx;
    logic [N_ENTRIES-1:0]         fire_mask;

    modport master (
        output flush, req, age, head_age, out_ready,
        input  gnt_valid, gnt_idx, fire_mask
    );

    modport slave (
        input  flush, req, age, head_age, out_ready,
        output gnt_valid, gnt_idx, fire_mask
    );
endinterface

// File: rtl/age_sel_issue.sv
// Oldest-first (wrap-aware ROB age) issue selector feeding N_GRANT registered FU ports; SEL_RR_TIE_EN enables rotating tie-break.
// Latency: req -> gnt_valid in one cycle; fire_mask is combinational from the port registers.
// Backpressure: a port with valid & !out_ready stalls holding its entry; flush empties every port.
module age_sel_issue #(
    parameter int N_ENTRIES = 16,
    parameter int N_GRANT   = 2,
    parameter int AGE_W     = 5
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    age_sel_issue_if.slave io
);
    localparam int IDX_W = $clog2(N_ENTRIES);
    localparam int KEY_W = AGE_W + IDX_W;

    logic [N_GRANT-1:0]              r_gnt_vld;
    logic [N_GRANT-1:0][IDX_W-1:0]   r_gnt_idx;
    logic [N_ENTRIES-1:0][AGE_W-1:0] w_age;
    logic [N_ENTRIES-1:0][AGE_W-1:0] w_rel_age;
    logic [N_ENTRIES-1:0]            w_held;
    logic [N_ENTRIES-1:0]            w_avail;
    logic [N_ENTRIES-1:0]            w_fire_mask;
    logic [N_GRANT-1:0]              w_free;
    logic [N_GRANT-1:0]              w_load;
    logic [N_GRANT-1:0][IDX_W-1:0]   w_sel_idx;
    logic [IDX_W-1:0]                w_tie_base;
    logic [IDX_W-1:0]                w_best_idx;
    logic [KEY_W-1:0]                w_key;
    logic [KEY_W-1:0]                w_best_key;
    logic                            w_found;

    assign w_age = io.age;

    always_comb begin
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_rel_age[i] = w_age[i] - io.head_age;
        end
    end

    // An entry stays held while its port fires, so the RS has a cycle to drop req.
    always_comb begin
        w_held      = '0;
        w_fire_mask = '0;
        w_free      = '0;
        for (int k = 0; k < N_GRANT; k++) begin
            w_free[k] = !r_gnt_vld[k] || io.out_ready[k];
            if (r_gnt_vld[k]) begin
                w_held[r_gnt_idx[k]] = 1'b1;
            end
            if (r_gnt_vld[k] && io.out_ready[k]) begin
                w_fire_mask[r_gnt_idx[k]] = 1'b1;
            end
        end
    end

    // Key = {relative age, tie rank}; tie rank is the index distance from the tie base.
    always_comb begin
        w_avail    = io.req & ~w_held;
        w_load     = '0;
        w_sel_idx  = '0;
        w_key      = '0;
        w_best_key = '0;
        w_best_idx = '0;
        w_found    = 1'b0;
        for (int k = 0; k < N_GRANT; k++) begin
            w_found    = 1'b0;
            w_best_key = '0;
            w_best_idx = '0;
            if (w_free[k]) begin
                for (int i = 0; i < N_ENTRIES; i++) begin
                    w_key = {w_rel_age[i], IDX_W'(i) - w_tie_base};
                    if (w_avail[i] && (!w_found || (w_key < w_best_key))) begin
                        w_found    = 1'b1;
                        w_best_key = w_key;
                        w_best_idx = IDX_W'(i);
                    end
                end
            end
            w_load[k]    = w_found;
            w_sel_idx[k] = w_best_idx;
            if (w_found) begin
                w_avail[w_best_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt_vld <= '0;
            r_gnt_idx <= '0;
        end else begin
            for (int k = 0; k < N_GRANT; k++) begin
                if (io.flush) begin
                    r_gnt_vld[k] <= 1'b0;
                end else if (w_free[k]) begin
                    r_gnt_vld[k] <= w_load[k];
                    if (w_load[k]) begin
                        r_gnt_idx[k] <= w_sel_idx[k];
                    end
                end
            end
        end
    end

`ifdef SEL_RR_TIE_EN
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_nxt;

    always_comb begin
        w_rr_nxt = r_rr_ptr;
        for (int k = 0; k < N_GRANT; k++) begin
            if (w_load[k]) begin
                w_rr_nxt = w_sel_idx[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr <= '0;
        end else if (!io.flush) begin
            r_rr_ptr <= w_rr_nxt;
        end
    end

    assign w_tie_base = r_rr_ptr;
`else
    assign w_tie_base = '0;
`endif

    assign io.gnt_valid = r_gnt_vld;
    assign io.gnt_idx   = r_gnt_idx;
    assign io.fire_mask = w_fire_mask;
endmodule
